display_scan_controller: RTL and testbench

- Sequences the timer's 4-digit multiplexed 7-segment display: scans digits 0..3, drives one anode at a time, decodes BCD to segments, and inserts a blanking gap between digits to stop ghosting.
- Holds shadow copies of the displayed digits and updates them only at frame boundaries, so the running time value never tears mid-scan.
- Sits between the timekeeping counters and the board pins; replaces the free-running digit-select counter as the owner of the scan sequence.

---
 rtl/timer_display_pkg.sv | 30 +++
 rtl/bcd_to_seg.sv | 25 ++
 rtl/display_scan_controller.sv | 210 +++++++++++++++++++++
 tb/tb_display_scan_controller.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_display_pkg
//  Description : Shared types and constants for the timer's multiplexed
//                7-segment display: scan state encoding, digit count,
//                segment constants and the active-high BCD segment table
//                (bit 0 = segment a ... bit 6 = segment g).
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ON    = 2'd1,
      ST_BLANK = 2'd2
   } scan_state_t;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_DASH = 7'h40;   // g only
   localparam logic [6:0] SEG_OFF  = 7'h00;

   // Index = BCD value; 10..15 are not decimal digits and show a dash.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
   };

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg
//  Description : Combinational BCD to 7-segment decode with selectable
//                output polarity.
//  Ports       : bcd [3:0] in  - digit value (10..15 decode to a dash)
//                seg [6:0] out - segments a..g, bit 0 = a, polarity per
//                                ACTIVE_LOW
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg
   import timer_display_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = ACTIVE_LOW ? ~SEG_TABLE[bcd] : SEG_TABLE[bcd];
   end

endmodule
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_controller
//  Description : Scan sequencer for a 4-digit multiplexed 7-segment display.
//                Lights one digit at a time for DWELL_CYCLES, blanks all
//                anodes for BLANK_CYCLES between digits, decodes shadowed BCD
//                digits and updates the shadows only at frame boundaries.
//  Ports       : clock         in  - system clock
//                reset_n       in  - asynchronous active-low reset
//                enable        in  - 1 scans, 0 keeps the display dark
//                digit_data    in  - four BCD digits, [3:0] = digit 0
//                dp_mask       in  - decimal point enable per digit
//                load          in  - level request to latch data into shadows
//                load_ack      out - pulse in the cycle the shadows update
//                anode         out - one-hot digit enable or all off
//                segments      out - segments a..g, bit 0 = a
//                dp            out - decimal point
//                digit_select  out - index of the current/last-lit digit
//                frame_start   out - pulse in the first ON cycle of digit 0
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan_controller
   import timer_display_pkg::*;
#(
   parameter int DWELL_CYCLES = 16384,
   parameter int BLANK_CYCLES = 256,
   parameter bit ACTIVE_LOW   = 1'b1,
   parameter bit LZ_BLANK     = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [15:0] digit_data,
   input  logic [3:0]  dp_mask,
   input  logic        load,
   output logic        load_ack,
   output logic [3:0]  anode,
   output logic [6:0]  segments,
   output logic        dp,
   output logic [1:0]  digit_select,
   output logic        frame_start
);

   localparam int C_CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

   localparam logic [C_CNT_W-1:0] C_DWELL_LAST = C_CNT_W'(DWELL_CYCLES - 1);
   localparam logic [C_CNT_W-1:0] C_BLANK_LAST = C_CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   localparam logic [3:0] C_AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [6:0] C_SEG_OFF = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic       C_DP_OFF  = ACTIVE_LOW;

   scan_state_t        r_state, w_state_nxt;
   logic [C_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]         r_sel, w_sel_nxt;
   logic [15:0]        r_shadow, w_shadow_nxt;
   logic [3:0]         r_dpm, w_dpm_nxt;
   logic               r_load_ack, r_frame_start, r_dp;
   logic [3:0]         r_anode, w_anode_nxt;
   logic [6:0]         r_segments, w_seg_nxt;
   logic               w_dp_nxt;
   logic               w_boundary, w_capture;
   logic [3:0]         w_digit, w_onehot, w_zero_above;
   logic [6:0]         w_seg_dec;
   logic               w_lz, w_dp_on;

   // ---------------------------------------------------------------------
   // Scan sequencing: next state, dwell/blank counter and digit index
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sel_nxt   = r_sel;
      if (!enable) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_sel_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_ON;
               w_cnt_nxt   = '0;
               w_sel_nxt   = '0;
            end
            ST_ON: begin
               if (r_cnt == C_DWELL_LAST) begin
                  w_cnt_nxt = '0;
                  if (BLANK_CYCLES == 0) begin
                     // No gap configured: hop straight to the next digit.
                     w_sel_nxt = r_sel + 2'd1;
                  end else begin
                     w_state_nxt = ST_BLANK;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            ST_BLANK: begin
               if (r_cnt == C_BLANK_LAST) begin
                  w_state_nxt = ST_ON;
                  w_cnt_nxt   = '0;
                  w_sel_nxt   = r_sel + 2'd1;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_sel_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_sel   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sel   <= w_sel_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Shadow update and output formation
   // ---------------------------------------------------------------------
   // Entering ON at digit 0 from anywhere other than ON digit 0 itself is a
   // frame boundary (IDLE->ON or the 3->0 wrap).
   always_comb begin
      w_boundary = (w_state_nxt == ST_ON) && (w_sel_nxt == 2'd0) &&
                   !((r_state == ST_ON) && (r_sel == 2'd0));
      // The requester still holds load during the ack cycle, so a request is
      // not taken twice back to back.
      w_capture  = load && !r_load_ack && ((r_state == ST_IDLE) || w_boundary);
      w_shadow_nxt = w_capture ? digit_data : r_shadow;
      w_dpm_nxt    = w_capture ? dp_mask    : r_dpm;
   end

   // Decode from the next-cycle digit so the registered anode, segments and
   // dp all switch on the same edge.
   always_comb begin
      w_digit = w_shadow_nxt[{w_sel_nxt, 2'b00} +: 4];
   end

   bcd_to_seg #(
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_bcd_to_seg (
      .bcd (w_digit),
      .seg (w_seg_dec)
   );

   always_comb begin
      // w_zero_above[k]: digit k and every more significant digit are zero.
      w_zero_above[3] = ~|w_shadow_nxt[15:12];
      w_zero_above[2] = w_zero_above[3] & ~|w_shadow_nxt[11:8];
      w_zero_above[1] = w_zero_above[2] & ~|w_shadow_nxt[7:4];
      w_zero_above[0] = 1'b0;
      w_lz     = LZ_BLANK && w_zero_above[w_sel_nxt];
      w_dp_on  = w_dpm_nxt[w_sel_nxt];
      w_onehot = 4'b0001 << w_sel_nxt;

      w_anode_nxt = C_AN_OFF;
      w_seg_nxt   = C_SEG_OFF;
      w_dp_nxt    = C_DP_OFF;
      if (w_state_nxt == ST_ON) begin
         // A suppressed leading zero keeps its anode only to show its dp.
         if (!w_lz || w_dp_on) begin
            w_anode_nxt = ACTIVE_LOW ? ~w_onehot : w_onehot;
         end
         if (!w_lz) begin
            w_seg_nxt = w_seg_dec;
         end
         w_dp_nxt = w_dp_on ^ ACTIVE_LOW;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_shadow      <= '0;
         r_dpm         <= '0;
         r_load_ack    <= 1'b0;
         r_frame_start <= 1'b0;
         r_anode       <= C_AN_OFF;
         r_segments    <= C_SEG_OFF;
         r_dp          <= C_DP_OFF;
      end else begin
         r_shadow      <= w_shadow_nxt;
         r_dpm         <= w_dpm_nxt;
         r_load_ack    <= w_capture;
         r_frame_start <= w_boundary;
         r_anode       <= w_anode_nxt;
         r_segments    <= w_seg_nxt;
         r_dp          <= w_dp_nxt;
      end
   end

   assign load_ack     = r_load_ack;
   assign frame_start  = r_frame_start;
   assign anode        = r_anode;
   assign segments     = r_segments;
   assign dp           = r_dp;
   assign digit_select = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scan_controller
//  Description : Self-checking bench for display_scan_controller. Two
//                instances: DWELL=8/BLANK=2 and DWELL=1/BLANK=0, both
//                active-low with leading-zero blanking. A frame-position
//                model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_controller;

   typedef struct {
      bit          run;
      int          t;      // cycle position within the current frame
      logic [15:0] sh;
      logic [3:0]  dpm;
      bit          ack;
      bit          fs;
   } mdl_t;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic [1:0] sel;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n, reset_n1;
   logic        enable, enable1, load, load1;
   logic [15:0] digit_data;
   logic [3:0]  dp_mask;

   logic        load_ack0, dp0, frame_start0;
   logic [3:0]  anode0;
   logic [6:0]  seg0;
   logic [1:0]  sel0;
   logic        load_ack1, dp1, frame_start1;
   logic [3:0]  anode1;
   logic [6:0]  seg1;
   logic [1:0]  sel1;

   int   n_chk = 0;
   int   n_err = 0;
   bit   cmp_on = 1'b0;
   mdl_t m0, m1;

   always #5 clock = ~clock;

   display_scan_controller #(
      .DWELL_CYCLES (8), .BLANK_CYCLES (2), .ACTIVE_LOW (1'b1), .LZ_BLANK (1'b1)
   ) u_dut0 (
      .clock (clock), .reset_n (reset_n), .enable (enable),
      .digit_data (digit_data), .dp_mask (dp_mask), .load (load),
      .load_ack (load_ack0), .anode (anode0), .segments (seg0), .dp (dp0),
      .digit_select (sel0), .frame_start (frame_start0)
   );

   display_scan_controller #(
      .DWELL_CYCLES (1), .BLANK_CYCLES (0), .ACTIVE_LOW (1'b1), .LZ_BLANK (1'b1)
   ) u_dut1 (
      .clock (clock), .reset_n (reset_n1), .enable (enable1),
      .digit_data (digit_data), .dp_mask (dp_mask), .load (load1),
      .load_ack (load_ack1), .anode (anode1), .segments (seg1), .dp (dp1),
      .digit_select (sel1), .frame_start (frame_start1)
   );

   // ---------------------------------------------------------------------
   // Model
   // ---------------------------------------------------------------------
   function automatic logic [6:0] seg_of(input logic [3:0] v);
      case (v)
         4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
         4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
         4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
         4'd9: return 7'h6F;  default: return 7'h40;
      endcase
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.run = 1'b0; m.t = 0; m.sh = '0; m.dpm = '0; m.ack = 1'b0; m.fs = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t m, input bit en, input bit ld,
                                     input logic [15:0] dd, input logic [3:0] dm,
                                     input int dwell, input int blank);
      mdl_t n;
      int   frame;
      bit   bnd, cap;
      n     = m;
      frame = 4 * (dwell + blank);
      bnd   = en && (!m.run || m.t == frame - 1);
      cap   = ld && !m.ack && (!m.run || bnd);
      if (cap) begin
         n.sh  = dd;
         n.dpm = dm;
      end
      n.ack = cap;
      n.fs  = bnd;
      if (!en) begin
         n.run = 1'b0; n.t = 0;
      end else if (!m.run) begin
         n.run = 1'b1; n.t = 0;
      end else begin
         n.t = (m.t + 1) % frame;
      end
      return n;
   endfunction

   function automatic exp_t mdl_out(input mdl_t m, input int dwell, input int blank);
      exp_t       e;
      int         per, d;
      bit         hide;
      logic [3:0] oh;
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.sel = 2'd0;
      if (m.run) begin
         per   = dwell + blank;
         d     = m.t / per;
         e.sel = 2'(d);
         if ((m.t % per) < dwell) begin
            hide  = (d > 0) && ((m.sh >> (4 * d)) == 16'd0);
            e.seg = hide ? 7'h7F : ~seg_of(m.sh[4*d +: 4]);
            e.dp  = ~m.dpm[d];
            oh    = 4'b0001 << d;
            e.an  = (hide && !m.dpm[d]) ? 4'hF : ~oh;
         end
      end
      return e;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) m0 <= mdl_reset();
      else          m0 <= mdl_step(m0, enable, load, digit_data, dp_mask, 8, 2);
   end

   always @(posedge clock or negedge reset_n1) begin
      if (!reset_n1) m1 <= mdl_reset();
      else           m1 <= mdl_step(m1, enable1, load1, digit_data, dp_mask, 1, 0);
   end

   // ---------------------------------------------------------------------
   // Checking helpers
   // ---------------------------------------------------------------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      exp_t e0, e1;
      e0 = mdl_out(m0, 8, 2);
      e1 = mdl_out(m1, 1, 0);
      chk("anode0", 32'(anode0), 32'(e0.an));
      chk("seg0",   32'(seg0),   32'(e0.seg));
      chk("dp0",    32'(dp0),    32'(e0.dp));
      chk("sel0",   32'(sel0),   32'(e0.sel));
      chk("fs0",    32'(frame_start0), 32'(m0.fs));
      chk("ack0",   32'(load_ack0),    32'(m0.ack));
      chk("anode1", 32'(anode1), 32'(e1.an));
      chk("seg1",   32'(seg1),   32'(e1.seg));
      chk("dp1",    32'(dp1),    32'(e1.dp));
      chk("sel1",   32'(sel1),   32'(e1.sel));
      chk("fs1",    32'(frame_start1), 32'(m1.fs));
      chk("ack1",   32'(load_ack1),    32'(m1.ack));
   endtask

   // Present a load to instance 0 and return at the negedge showing load_ack.
   task automatic do_load(input logic [15:0] d, input logic [3:0] m, input string nm);
      digit_data = d;
      dp_mask    = m;
      load       = 1'b1;
      for (int k = 0; k < 100 && load_ack0 !== 1'b1; k++) @(negedge clock);
      chk({nm, "_ack_wait"}, 32'(load_ack0), 32'd1);
      #1 load = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      logic [3:0] pat [4];
      int         n;
      pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;

      reset_n = 1'b0; reset_n1 = 1'b0; enable = 1'b0; enable1 = 1'b0;
      load = 1'b0; load1 = 1'b0; digit_data = '0; dp_mask = '0;

      fork
         forever begin
            @(negedge clock);
            if (cmp_on) compare_all();
         end
      join_none

      repeat (3) @(negedge clock);
      chk("rst_anode", 32'(anode0), 32'hF);
      chk("rst_seg",   32'(seg0),   32'h7F);
      chk("rst_dp",    32'(dp0),    32'd1);
      chk("rst_sel",   32'(sel0),   32'd0);
      chk("rst_ack",   32'(load_ack0), 32'd0);
      chk("rst_fs",    32'(frame_start0), 32'd0);
      #1 reset_n = 1'b1; reset_n1 = 1'b1; cmp_on = 1'b1;

      // Load 1234 while dark, then enable: digit 0 shows "4".
      @(negedge clock); #1;
      do_load(16'h1234, 4'h0, "idle_load");
      enable = 1'b1;
      @(negedge clock);
      chk("first_anode", 32'(anode0), 32'(4'b1110));
      chk("first_seg4",  32'(seg0),   32'h19);
      chk("first_fs",    32'(frame_start0), 32'd1);

      // Frame period = 4 * (8 + 2).
      @(negedge clock);
      n = 1;
      while (frame_start0 !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("frame_period", 32'(n), 32'd40);

      // Load requested mid-frame while digit 2 is lit.
      for (int k = 0; k < 80 && !(sel0 == 2'd2 && anode0 == 4'b1011); k++) @(negedge clock);
      chk("wait_digit2", 32'(sel0 == 2'd2 && anode0 == 4'b1011), 32'd1);
      #1;
      do_load(16'h5678, 4'h0, "mid_load");
      chk("mid_fs_with_ack", 32'(frame_start0), 32'd1);
      chk("mid_anode",       32'(anode0), 32'(4'b1110));
      chk("mid_seg8",        32'(seg0),   32'h00);

      // Leading-zero blanking with a dp on the blanked top digit.
      @(negedge clock); #1;
      do_load(16'h0070, 4'b1000, "lz_load");
      chk("lz_d0_anode", 32'(anode0), 32'(4'b1110));
      chk("lz_d0_seg0",  32'(seg0),   32'h40);
      for (int k = 0; k < 80 && !(sel0 == 2'd1 && anode0 != 4'hF); k++) @(negedge clock);
      chk("lz_d1_anode", 32'(anode0), 32'(4'b1101));
      chk("lz_d1_seg7",  32'(seg0),   32'h78);
      for (int k = 0; k < 80 && !(sel0 == 2'd3 && anode0 != 4'hF); k++) @(negedge clock);
      chk("lz_d3_anode", 32'(anode0), 32'(4'b0111));
      chk("lz_d3_seg",   32'(seg0),   32'h7F);
      chk("lz_d3_dp",    32'(dp0),    32'd0);

      // All zeros: only digit 0 is lit.
      #1;
      do_load(16'h0000, 4'h0, "zero_load");
      chk("zero_d0_seg", 32'(seg0), 32'h40);
      for (int k = 0; k < 80 && sel0 != 2'd1; k++) @(negedge clock);
      chk("zero_d1_dark", 32'(anode0), 32'hF);

      // Invalid BCD in digit 0 shows a dash.
      #1;
      do_load(16'h123C, 4'h0, "bad_load");
      chk("bad_dash", 32'(seg0), 32'h3F);

      // Drop enable during the blank after digit 1.
      for (int k = 0; k < 80 && !(sel0 == 2'd1 && anode0 == 4'hF); k++) @(negedge clock);
      chk("wait_blank1", 32'(sel0 == 2'd1 && anode0 == 4'hF), 32'd1);
      #1 enable = 1'b0;
      @(negedge clock);
      chk("dis_anode", 32'(anode0), 32'hF);
      chk("dis_sel",   32'(sel0),   32'd0);
      @(negedge clock);
      #1 enable = 1'b1;
      @(negedge clock);
      chk("reen_fs",    32'(frame_start0), 32'd1);
      chk("reen_anode", 32'(anode0), 32'(4'b1110));

      // Instance 1: one-cycle dwell, no blank gap.
      #1;
      digit_data = 16'h4321; dp_mask = 4'h0; load1 = 1'b1;
      for (int k = 0; k < 20 && load_ack1 !== 1'b1; k++) @(negedge clock);
      chk("fast_ack_wait", 32'(load_ack1), 32'd1);
      #1 load1 = 1'b0; enable1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk("fast_anode_seq", 32'(anode1), 32'(pat[i % 4]));
      end

      // Asynchronous reset mid-scan with a load held.
      for (int k = 0; k < 10 && sel1 != 2'd1; k++) @(negedge clock);
      #1 digit_data = 16'h9999; load1 = 1'b1;
      #2 reset_n1 = 1'b0;
      #1;
      chk("areset_anode", 32'(anode1), 32'hF);
      chk("areset_seg",   32'(seg1),   32'h7F);
      chk("areset_dp",    32'(dp1),    32'd1);
      chk("areset_ack",   32'(load_ack1), 32'd0);
      @(negedge clock);
      chk("areset_no_ack", 32'(load_ack1), 32'd0);
      #1 load1 = 1'b0; reset_n1 = 1'b1;

      repeat (12) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
